// File: rtl/mult_pkg.sv
// Shared types and the widening multiply helper for the handshaked multiplier.
// Request/response structs describe the default-width transaction seen by the AFU.
package mult_pkg;

  localparam int MULT_DATA_LEN       = 32;
  localparam int MULT_PIPELINE_STAGE = 2;
  localparam int MULT_TAG_W          = 8;
  // Widest operand the helper accepts; narrower callers widen into it.
  localparam int MULT_MAX_LEN        = 64;

  typedef struct packed {
    logic [MULT_DATA_LEN-1:0] a;
    logic [MULT_DATA_LEN-1:0] b;
    logic                     is_signed;
    logic [MULT_TAG_W-1:0]    tag;
  } t_mult_req;

  typedef struct packed {
    logic [2*MULT_DATA_LEN-1:0] result;
    logic [MULT_TAG_W-1:0]      tag;
  } t_mult_rsp;

  // Extends both operands per mode and multiplies. The product of the
  // extended operands is exact modulo 2**(2*MULT_MAX_LEN), so any caller
  // keeping only its own low 2*DATA_LEN bits gets the exact result.
  function automatic logic [2*MULT_MAX_LEN-1:0] mult_ext_mul(
    input logic [MULT_MAX_LEN-1:0] a,
    input logic [MULT_MAX_LEN-1:0] b,
    input logic                    is_signed
  );
    logic [2*MULT_MAX_LEN-1:0] a_x;
    logic [2*MULT_MAX_LEN-1:0] b_x;
    a_x = is_signed ? (2*MULT_MAX_LEN)'(signed'(a)) : (2*MULT_MAX_LEN)'(a);
    b_x = is_signed ? (2*MULT_MAX_LEN)'(signed'(b)) : (2*MULT_MAX_LEN)'(b);
    return a_x * b_x;
  endfunction

endpackage

// File: rtl/mult_pipe_slot.sv
// One valid/ready register slot carrying an arbitrary payload type.
// Accepts whenever empty or when its own content leaves in the same cycle.
module mult_pipe_slot #(
  parameter type payload_t = logic
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     flush,
  input  logic     in_valid,
  output logic     in_ready,
  input  payload_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output payload_t out_data
);

  logic     valid_q;
  payload_t data_q;

  // Bubble collapsing: an empty slot always takes new data, independent of out_ready.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // NOTE: state is updated with <= so every slot samples its neighbour's
  // pre-edge value; blocking assignments here would shift data through
  // several slots in one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      // NOTE: the payload register is reset as well so out_result/out_tag
      // read zero out of reset, not just out_valid.
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end

endmodule

// File: rtl/mult_pipe_hs.sv
// Handshaked signed/unsigned multiplier: a chain of PIPELINE_STAGE slots,
// the product computed in front of slot 0 and carried unchanged afterwards.
module mult_pipe_hs
  import mult_pkg::*;
#(
  parameter int DATA_LEN       = MULT_DATA_LEN,
  parameter int PIPELINE_STAGE = MULT_PIPELINE_STAGE,
  parameter int TAG_W          = MULT_TAG_W
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_LEN-1:0]                 in_a,
  input  logic [DATA_LEN-1:0]                 in_b,
  input  logic                                in_signed,
  input  logic [TAG_W-1:0]                    in_tag,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [2*DATA_LEN-1:0]               out_result,
  output logic [TAG_W-1:0]                    out_tag,
  output logic [$clog2(PIPELINE_STAGE+1)-1:0] inflight
);

  localparam int PW    = 2 * DATA_LEN;
  localparam int CNT_W = $clog2(PIPELINE_STAGE + 1);

  typedef struct packed {
    logic [PW-1:0]    result;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic [MULT_MAX_LEN-1:0] a_wide;
  logic [MULT_MAX_LEN-1:0] b_wide;
  rsp_t                    slot_in;

  // Index k is the input side of slot k; index PIPELINE_STAGE is the output port.
  logic [PIPELINE_STAGE:0] stg_valid;
  logic [PIPELINE_STAGE:0] stg_ready;
  rsp_t                    stg_data [PIPELINE_STAGE+1];

  logic                    in_fire;
  logic                    out_fire;
  logic [CNT_W-1:0]        inflight_q;

  // Widening to the helper's width must follow the mode, or the helper
  // would see a different integer than the caller meant.
  always_comb begin
    a_wide         = in_signed ? MULT_MAX_LEN'(signed'(in_a)) : MULT_MAX_LEN'(in_a);
    b_wide         = in_signed ? MULT_MAX_LEN'(signed'(in_b)) : MULT_MAX_LEN'(in_b);
    slot_in.result = PW'(mult_ext_mul(a_wide, b_wide, in_signed));
    slot_in.tag    = in_tag;
  end

  assign stg_valid[0]              = in_valid;
  assign stg_data[0]               = slot_in;
  assign stg_ready[PIPELINE_STAGE] = out_ready;

  for (genvar k = 0; k < PIPELINE_STAGE; k++) begin : g_slot
    mult_pipe_slot #(
      .payload_t (rsp_t)
    ) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (stg_valid[k]),
      .in_ready  (stg_ready[k]),
      .in_data   (stg_data[k]),
      .out_valid (stg_valid[k+1]),
      .out_ready (stg_ready[k+1]),
      .out_data  (stg_data[k+1])
    );
  end

  // A flushing cycle refuses input so the coincident operand is visibly dropped.
  assign in_ready   = stg_ready[0] && !flush;
  assign out_valid  = stg_valid[PIPELINE_STAGE];
  assign out_result = stg_data[PIPELINE_STAGE].result;
  assign out_tag    = stg_data[PIPELINE_STAGE].tag;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= '0;
    end else if (flush) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_q + CNT_W'(in_fire) - CNT_W'(out_fire);
    end
  end

  assign inflight = inflight_q;

endmodule

// File: tb/tb_mult_pipe_hs.sv
// Directed bench for mult_pipe_hs at DATA_LEN=32, PIPELINE_STAGE=2, TAG_W=8.
// Inputs change 1 ns after the rising edge; outputs are read in that window.
module tb_mult_pipe_hs;
  import mult_pkg::*;

  localparam int DL = 32;
  localparam int PS = 2;
  localparam int TW = 8;
  localparam int CW = $clog2(PS + 1);

  logic            clk;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [DL-1:0]   in_a;
  logic [DL-1:0]   in_b;
  logic            in_signed;
  logic [TW-1:0]   in_tag;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [2*DL-1:0] out_result;
  logic [TW-1:0]   out_tag;
  logic [CW-1:0]   inflight;

  int checks = 0;
  int errors = 0;

  mult_pipe_hs #(
    .DATA_LEN       (DL),
    .PIPELINE_STAGE (PS),
    .TAG_W          (TW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_signed  (in_signed),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .inflight   (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input t_mult_req r);
    in_valid  = 1'b1;
    in_a      = r.a;
    in_b      = r.b;
    in_signed = r.is_signed;
    in_tag    = r.tag;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    in_tag    = '0;
  endtask

  // Issues one operation into an empty pipe and waits (bounded) for its result.
  task automatic exec_op(input t_mult_req r, output logic [2*DL-1:0] res,
                         output logic [TW-1:0] tg, output bit timeout);
    out_ready = 1'b1;
    drive(r);
    step();
    idle();
    timeout = 1'b1;
    res     = '0;
    tg      = '0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        res     = out_result;
        tg      = out_tag;
        timeout = 1'b0;
        break;
      end
      step();
    end
    if (!timeout) step();
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle();
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++;
    if (out_result !== '0) begin errors++; $display("FAIL reset_out_result got %h expected 0", out_result); end
    checks++;
    if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got %h expected 0", out_tag); end
    checks++;
    if (inflight !== '0) begin errors++; $display("FAIL reset_inflight got %0d expected 0", inflight); end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
    step();
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    drive('{a: 32'd3, b: 32'd7, is_signed: 1'b0, tag: 8'd5});
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready got %b expected 1", in_ready); end
    step();
    idle();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid got %b expected 0", out_valid); end
    checks++;
    if (inflight !== CW'(1)) begin errors++; $display("FAIL lat_inflight got %0d expected 1", inflight); end
    step();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %b expected 1", out_valid); end
    checks++;
    if (out_result !== 64'd21) begin errors++; $display("FAIL lat_result got %h expected %h", out_result, 64'd21); end
    checks++;
    if (out_tag !== 8'd5) begin errors++; $display("FAIL lat_tag got %h expected 05", out_tag); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_drained got %b expected 0", out_valid); end
    checks++;
    if (inflight !== '0) begin errors++; $display("FAIL lat_inflight_end got %0d expected 0", inflight); end
  endtask

  task automatic test_signed();
    t_mult_req       vec [6];
    logic [2*DL-1:0] exp [6];
    logic [2*DL-1:0] res;
    logic [TW-1:0]   tg;
    bit              to;
    vec[0] = '{a: 32'hFFFF_FFFF, b: 32'd2,          is_signed: 1'b1, tag: 8'h31};
    exp[0] = 64'hFFFF_FFFF_FFFF_FFFE;
    vec[1] = '{a: 32'hFFFF_FFFF, b: 32'd2,          is_signed: 1'b0, tag: 8'h32};
    exp[1] = 64'h0000_0001_FFFF_FFFE;
    vec[2] = '{a: 32'h8000_0000, b: 32'h8000_0000, is_signed: 1'b1, tag: 8'h33};
    exp[2] = 64'h4000_0000_0000_0000;
    vec[3] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, is_signed: 1'b0, tag: 8'h34};
    exp[3] = 64'hFFFF_FFFE_0000_0001;
    vec[4] = '{a: 32'hFFFF_FFFD, b: 32'd5,          is_signed: 1'b1, tag: 8'h35};
    exp[4] = 64'hFFFF_FFFF_FFFF_FFF1;
    vec[5] = '{a: 32'h7FFF_FFFF, b: 32'h8000_0000, is_signed: 1'b1, tag: 8'h36};
    exp[5] = 64'hC000_0000_8000_0000;
    for (int i = 0; i < 6; i++) begin
      exec_op(vec[i], res, tg, to);
      checks++;
      if (to) begin errors++; $display("FAIL mode_timeout vec %0d no out_valid within 8 cycles", i); end
      checks++;
      if (res !== exp[i]) begin errors++; $display("FAIL mode_result vec %0d got %h expected %h", i, res, exp[i]); end
      checks++;
      if (tg !== vec[i].tag) begin errors++; $display("FAIL mode_tag vec %0d got %h expected %h", i, tg, vec[i].tag); end
    end
  endtask

  task automatic test_back_to_back();
    int rx      = 0;
    bit started = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c < 10) begin
        drive('{a: 32'(c + 1), b: 32'(c + 2), is_signed: 1'b0, tag: 8'(8'h40 + c)});
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cycle %0d got %b expected 1", c, in_ready); end
      end else begin
        idle();
      end
      step();
      if (rx < 10) begin
        if (started) begin
          checks++;
          if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_gap cycle %0d got %b expected 1", c, out_valid); end
        end
        if (out_valid === 1'b1) begin
          started = 1'b1;
          checks++;
          if (out_tag !== 8'(8'h40 + rx)) begin
            errors++; $display("FAIL b2b_tag idx %0d got %h expected %h", rx, out_tag, 8'(8'h40 + rx));
          end
          checks++;
          if (out_result !== 64'((rx + 1) * (rx + 2))) begin
            errors++; $display("FAIL b2b_result idx %0d got %h expected %h", rx, out_result, 64'((rx + 1) * (rx + 2)));
          end
          rx++;
        end
      end
    end
    checks++;
    if (rx != 10) begin errors++; $display("FAIL b2b_count got %0d expected 10", rx); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive('{a: 32'd2, b: 32'd3, is_signed: 1'b0, tag: 8'h21});
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_a got %b expected 1", in_ready); end
    step();
    drive('{a: 32'd4, b: 32'd5, is_signed: 1'b0, tag: 8'h22});
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_b got %b expected 1", in_ready); end
    step();
    drive('{a: 32'd6, b: 32'd7, is_signed: 1'b0, tag: 8'h23});
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready cycle %0d got %b expected 0", i, in_ready); end
      checks++;
      if (inflight !== CW'(2)) begin errors++; $display("FAIL bp_inflight cycle %0d got %0d expected 2", i, inflight); end
      checks++;
      if (out_valid !== 1'b1 || out_result !== 64'd6 || out_tag !== 8'h21) begin
        errors++; $display("FAIL bp_hold cycle %0d got v=%b r=%h t=%h expected v=1 r=6 t=21", i, out_valid, out_result, out_tag);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b expected 1", in_ready); end
    step();
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 64'd20 || out_tag !== 8'h22) begin
      errors++; $display("FAIL bp_drain_b got v=%b r=%h t=%h expected v=1 r=14 t=22", out_valid, out_result, out_tag);
    end
    checks++;
    if (inflight !== CW'(2)) begin errors++; $display("FAIL bp_inflight_release got %0d expected 2", inflight); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 64'd42 || out_tag !== 8'h23) begin
      errors++; $display("FAIL bp_drain_c got v=%b r=%h t=%h expected v=1 r=2a t=23", out_valid, out_result, out_tag);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || inflight !== '0) begin
      errors++; $display("FAIL bp_empty got v=%b inflight=%0d expected v=0 inflight=0", out_valid, inflight);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive('{a: 32'd5, b: 32'd6, is_signed: 1'b0, tag: 8'h51});
    step();
    drive('{a: 32'd7, b: 32'd8, is_signed: 1'b0, tag: 8'h52});
    step();
    checks++;
    if (inflight !== CW'(2)) begin errors++; $display("FAIL flush_pre_inflight got %0d expected 2", inflight); end
    out_ready = 1'b1;
    drive('{a: 32'd9, b: 32'd9, is_signed: 1'b0, tag: 8'h53});
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b expected 0", in_ready); end
    step();
    flush = 1'b0;
    idle();
    checks++;
    if (inflight !== '0) begin errors++; $display("FAIL flush_inflight got %0d expected 0", inflight); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid cycle %0d got %b expected 0", i, out_valid); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [2*DL-1:0] res;
    logic [TW-1:0]   tg;
    bit              to;
    out_ready = 1'b0;
    drive('{a: 32'd11, b: 32'd12, is_signed: 1'b0, tag: 8'h61});
    step();
    drive('{a: 32'd13, b: 32'd14, is_signed: 1'b0, tag: 8'h62});
    step();
    idle();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %b expected 1", out_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b expected 0", out_valid); end
    checks++;
    if (inflight !== '0 || out_result !== '0) begin
      errors++; $display("FAIL rmid_state got inflight=%0d r=%h expected 0 and 0", inflight, out_result);
    end
    step();
    #3;
    reset_n = 1'b1;
    step();
    exec_op('{a: 32'h0001_0000, b: 32'h0001_0000, is_signed: 1'b0, tag: 8'h77}, res, tg, to);
    checks++;
    if (to) begin errors++; $display("FAIL rmid_timeout no out_valid within 8 cycles"); end
    checks++;
    if (res !== 64'h0000_0001_0000_0000 || tg !== 8'h77) begin
      errors++; $display("FAIL rmid_fresh got r=%h t=%h expected r=0000000100000000 t=77", res, tg);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_pipe_hs.md
# mult_pipe_hs

Parametrised, handshaked successor to the fixed-latency multiplier used by the multiply AFU. Accepts one operand pair per cycle over a valid/ready interface, supports per-transaction signed/unsigned mode, and returns the full 2×DATA_LEN product with a caller tag after a fixed pipeline latency. Supports backpressure with bubble collapsing, so the AFU no longer counts wait cycles and no longer needs a divided clock.

## Interface
Parameters:
- DATA_LEN, 32, operand width (≥2)
- PIPELINE_STAGE, 2, register stages from input to output (≥1)
- TAG_W, 8, width of the opaque tag carried with each operation

Ports:
- clk  in  1  single clock; all state on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept this cycle
- in_a, in_b  in  DATA_LEN  operands
- in_signed  in  1  1 = two's-complement multiply, 0 = unsigned
- in_tag  in  TAG_W  returned unchanged with the result
- flush  in  1  synchronous; drops all in-flight operations
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result this cycle
- out_result  out  2*DATA_LEN  product
- out_tag  out  TAG_W  tag of this result
- inflight  out  $clog2(PIPELINE_STAGE+1)  occupied stages

## Operation
- Transfer on a port occurs only on a rising edge where valid && ready.
- Arithmetic: extend each operand to DATA_LEN+1 bits (sign-extend if in_signed, else zero-extend), multiply, keep the low 2*DATA_LEN bits. The result is exact for both modes.
- The pipeline has PIPELINE_STAGE slots, each holding {valid, result/partial, tag}. The last slot drives out_*.
- Slot k advances when it is empty, or when slot k+1 advances. For the last slot, "slot k+1 advances" means out_ready.
- in_ready = slot 0 empty or slot 0 advancing. This path is combinational from out_ready.
- Results leave strictly in acceptance order. No reordering and no drops except on flush or reset.
- flush = 1: all slot valids clear at the next edge. in_ready = 0 during the flush cycle. inflight = 0 after that edge.
- When flush and an input handshake coincide, flush wins and the input is discarded.
- While out_valid && !out_ready, out_result and out_tag hold stable.
- inflight counts valid slots. It is registered, updated the same edge as the slots, and never exceeds PIPELINE_STAGE.

## Timing
- Reset: all slot valids = 0; out_valid = 0; out_result = 0; out_tag = 0; inflight = 0; in_ready = 1 once reset_n deasserts. Data registers also clear.
- Reset assertion mid-operation discards every in-flight operation immediately, without waiting for a clock edge.
- Latency: an operation accepted at edge e shows out_valid = 1 right after edge e+PIPELINE_STAGE−1, provided it is not stalled.
- Throughput: 1 operation/cycle when out_ready is held 1.
- Full: with all slots valid and out_ready = 0, in_ready = 0. When out_ready returns to 1, in_ready = 1 in that same cycle.
- Bubbles collapse: a stalled output does not stall upstream slots that still have an empty slot ahead of them.

## Structure
- Package mult_pkg:
  - typedef t_mult_req {a, b, is_signed, tag}
  - typedef t_mult_rsp {result, tag}
  - localparam defaults
  - function mult_ext_mul(a, b, is_signed)
- Sub-module mult_pipe_slot: one valid/ready register slot, parameterised on payload type.
  - Instantiated PIPELINE_STAGE times via generate.
  - Slot 0 payload is computed by mult_ext_mul.
  - Later slots pass the payload through, leaving room for retiming.

## Test plan
- DATA_LEN=32, PIPELINE_STAGE=2, unsigned, a=3, b=7, tag=5, out_ready=1 → out_valid 1 cycle after accept edge +1, result=21, tag=5.
- Signed a=0xFFFFFFFF (−1), b=2 → result 0xFFFFFFFF_FFFFFFFE. Same operands unsigned → 0x00000001_FFFFFFFE.
- Stream 10 back-to-back ops with out_ready=1 → 10 consecutive out_valid cycles, tags in order, in_ready never 0.
- out_ready=0 while pushing 3 ops, PIPELINE_STAGE=2:
  - exactly 2 accepted, then in_ready=0, inflight=2;
  - out_result held stable;
  - release out_ready → results drain in order, third op accepted the same cycle.
- flush with 2 in flight and in_valid=1 → no out_valid afterwards, inflight=0, the coincident input is lost.
- Assert reset_n=0 between edges with ops in flight → out_valid drops at once; after release, a fresh op returns the correct result.
